// File: rtl/prog_fetch_seq.sv
// Fetch/issue sequencer: owns the PC, registers {tag, instr} from program memory, issues to execute.
// Build option: define PROG_FETCH_WRAP_EN to wrap the PC to 0 past the last program word instead of halting.
module prog_fetch_seq #(
    parameter int ADDR_W   = 4,
    parameter int INSTR_W  = 42,
    parameter int PROG_LEN = 7,
    parameter int RESET_PC = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    output logic [ADDR_W-1:0]         pc_addr,
    input  logic [ADDR_W+INSTR_W-1:0] mem_line,
    output logic [INSTR_W-1:0]        instr,
    output logic [ADDR_W-1:0]         instr_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    input  logic                      jump_req,
    input  logic [ADDR_W-1:0]         jump_addr,
    output logic                      halted,
    output logic                      fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [ADDR_W:0]   LEN    = (ADDR_W+1)'(PROG_LEN);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    state_t               state, state_d;
    logic [ADDR_W-1:0]    pc_d, instr_pc_d, seq_pc, line_tag;
    logic [INSTR_W-1:0]   instr_d;
    logic                 valid_d, halted_d, fault_d;

    assign line_tag = mem_line[ADDR_W+INSTR_W-1 -: ADDR_W];
    assign seq_pc   = pc_addr + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc_addr     <= RST_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_d;
            pc_addr     <= pc_d;
            instr       <= instr_d;
            instr_pc    <= instr_pc_d;
            instr_valid <= valid_d;
            halted      <= halted_d;
            fault       <= fault_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc_addr;
        instr_d    = instr;
        instr_pc_d = instr_pc;
        valid_d    = instr_valid;
        halted_d   = halted;
        fault_d    = fault;
        case (state)
            S_IDLE: begin
                if (start && !stop) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    instr_d    = mem_line[INSTR_W-1:0];
                    instr_pc_d = pc_addr;
                    if (line_tag != pc_addr) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        valid_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                // stop outranks a same-cycle handshake so the pending instr is refetched on resume
                if (stop) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    if (jump_req) begin
                        if ({1'b0, jump_addr} >= LEN) begin
                            state_d = S_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            pc_d    = jump_addr;
                            state_d = S_FETCH;
                        end
                    end else if ({1'b0, seq_pc} >= LEN) begin
`ifdef PROG_FETCH_WRAP_EN
                        pc_d     = '0;
                        state_d  = S_FETCH;
`else
                        state_d  = S_HALT;
                        halted_d = 1'b1;
`endif
                    end else begin
                        pc_d    = seq_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT, S_FAULT: begin
                valid_d = 1'b0;
                if (start && !stop) begin
                    pc_d     = RST_PC;
                    halted_d = 1'b0;
                    fault_d  = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_prog_fetch_seq.sv
// Self-checking bench for prog_fetch_seq: cycle table plus hand-written corner sequences,
// with a scoreboard of expected PCs consumed at each execute handshake.
module tb_prog_fetch_seq;

    localparam int AW = 4;
    localparam int IW = 42;

    logic            clk = 1'b0;
    logic            rst, start, stop, instr_ready, jump_req;
    logic [AW-1:0]   jump_addr, pc_addr, instr_pc;
    logic [AW+IW-1:0] mem_line;
    logic [IW-1:0]   instr;
    logic            instr_valid, halted, fault;
    logic            bad_tag;

    int total = 0;
    int bad   = 0;
    logic [AW-1:0] exp_q[$];

    typedef struct {
        bit       s, sp, r, j;
        bit [3:0] ja;
        bit [3:0] pc;
        bit       v;
        bit [3:0] ipc;
        bit       h, f;
    } vec_t;

    vec_t tbl[19];

    always #5 clk = ~clk;

    prog_fetch_seq #(.ADDR_W(AW), .INSTR_W(IW), .PROG_LEN(7), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .pc_addr(pc_addr), .mem_line(mem_line),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .jump_req(jump_req), .jump_addr(jump_addr),
        .halted(halted), .fault(fault)
    );

    function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
        logic [11:0] lo;
        lo = 12'(a * 37 + 11);
        return {a[1:0], a ^ 4'h5, 8'h3C, a, a, 8'hA5, lo};
    endfunction

    always_comb mem_line = {(bad_tag && pc_addr == 4'd3) ? 4'hF : pc_addr, word(pc_addr)};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] pc, input logic v,
                              input logic [3:0] ipc, input logic h, input logic f);
        chk({tag, ".pc_addr"}, pc_addr, pc);
        chk({tag, ".valid"}, instr_valid, v);
        chk({tag, ".instr_pc"}, instr_pc, ipc);
        chk({tag, ".halted"}, halted, h);
        chk({tag, ".fault"}, fault, f);
    endtask

    task automatic do_reset();
        start = 0; stop = 0; instr_ready = 0; jump_req = 0; jump_addr = 0;
        chk("sb_empty", exp_q.size(), 0);
        exp_q.delete();
        rst = 0;
        #1;
        check_outs("reset", 0, 0, 0, 0, 0);
        chk("reset.instr", instr, 0);
        step();
        step();
        rst = 1;
        step();
        check_outs("idle", 0, 0, 0, 0, 0);
    endtask

    // handshake monitor: every accepted instruction must match the next expected PC
    always @(negedge clk) begin : mon
        logic [AW-1:0] e;
        if (rst && instr_valid && instr_ready && !stop) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL hs_unexpected: got pc %0h expected none", instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("hs_pc", instr_pc, e);
                chk("hs_instr", instr, word(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 0; start = 0; stop = 0; instr_ready = 0; jump_req = 0; jump_addr = 0; bad_tag = 0;
        // s sp r j ja | pc v ipc h f
        tbl[0]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 0};
        tbl[4]  = '{1, 0, 1, 0, 0, 2, 0, 1, 0, 0};
        tbl[5]  = '{1, 0, 1, 0, 0, 2, 1, 2, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 2, 1, 2, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 0, 2, 1, 2, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 2, 1, 2, 0, 0};
        tbl[9]  = '{1, 0, 0, 0, 0, 2, 1, 2, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 2, 1, 2, 0, 0};
        tbl[11] = '{1, 0, 1, 0, 0, 3, 0, 2, 0, 0};
        tbl[12] = '{1, 0, 0, 1, 0, 3, 1, 3, 0, 0};
        tbl[13] = '{1, 0, 0, 1, 0, 3, 1, 3, 0, 0};
        tbl[14] = '{1, 0, 1, 0, 0, 4, 0, 3, 0, 0};
        tbl[15] = '{1, 0, 1, 0, 0, 4, 1, 4, 0, 0};
        tbl[16] = '{1, 0, 1, 1, 1, 1, 0, 4, 0, 0};
        tbl[17] = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 0};
        tbl[18] = '{1, 0, 1, 0, 0, 2, 0, 1, 0, 0};

        step();
        do_reset();

        // sequential run, ready stall at PC 2, ignored jumps, taken jump at PC 4
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(1);
        for (int i = 0; i < 19; i++) begin
            start = tbl[i].s; stop = tbl[i].sp; instr_ready = tbl[i].r;
            jump_req = tbl[i].j; jump_addr = tbl[i].ja;
            step();
            check_outs($sformatf("row%0d", i), tbl[i].pc, tbl[i].v, tbl[i].ipc, tbl[i].h, tbl[i].f);
            if (tbl[i].v) chk($sformatf("row%0d.instr", i), instr, word(tbl[i].ipc));
        end

        // run to the end of the program
        jump_req = 0; jump_addr = 0;
        for (int p = 2; p < 7; p++) exp_q.push_back(4'(p));
`ifdef PROG_FETCH_WRAP_EN
        exp_q.push_back(0);
`endif
        for (int i = 0; i < 10; i++) step();
`ifdef PROG_FETCH_WRAP_EN
        check_outs("wrap", 0, 0, 6, 0, 0);
        step();
        check_outs("wrap_issue", 0, 1, 0, 0, 0);
        step();
        check_outs("wrap_next", 1, 0, 0, 0, 0);
`else
        check_outs("halt", 6, 0, 6, 1, 0);
        step();
        check_outs("halt_restart", 0, 0, 6, 0, 0);
`endif
        do_reset();

        // out-of-range jump from PC 1 faults, start restarts at PC 0
        exp_q.push_back(0); exp_q.push_back(1);
        start = 1; instr_ready = 1;
        for (int i = 0; i < 4; i++) step();
        jump_req = 1; jump_addr = 9;
        step();
        check_outs("jfault", 1, 0, 1, 0, 1);
        jump_req = 0; jump_addr = 0;
        step();
        check_outs("jfault_restart", 0, 0, 1, 0, 0);
        instr_ready = 0;
        step();
        check_outs("jfault_issue", 0, 1, 0, 0, 0);
        do_reset();

        // corrupted tag at PC 3
        bad_tag = 1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        start = 1; instr_ready = 1;
        for (int i = 0; i < 7; i++) step();
        check_outs("tag_fetch3", 3, 0, 2, 0, 0);
        step();
        check_outs("tag_fault", 3, 0, 3, 0, 1);
        start = 0; bad_tag = 0;
        step();
        check_outs("tag_fault_hold", 3, 0, 3, 0, 1);
        do_reset();

        // stop with same-cycle handshake at PC 5, then resume
        for (int p = 0; p < 5; p++) exp_q.push_back(4'(p));
        start = 1; instr_ready = 1;
        for (int i = 0; i < 12; i++) step();
        check_outs("issue5", 5, 1, 5, 0, 0);
        stop = 1;
        step();
        check_outs("stopped", 5, 0, 5, 0, 0);
        stop = 0;
        exp_q.push_back(5);
        step();
        check_outs("resume_fetch", 5, 0, 5, 0, 0);
        step();
        check_outs("resume_issue", 5, 1, 5, 0, 0);
        chk("resume_instr", instr, word(5));
        step();
        check_outs("resume_next", 6, 0, 5, 0, 0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
